fetch_prefetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the next-generation core. It replaces the fixed PC register, PC+4 adder and PC mux with one block.
- Holds the fetch PC and issues requests to instruction memory over a ready/valid interface that tolerates variable latency.
- Buffers returned instructions with their PCs in a DEPTH-entry in-order queue feeding decode.
- Handles redirects (taken branch, JAL, JALR) by flushing the queue and discarding stale in-flight responses. Supports halt.

---
 rtl/fetch_prefetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: fetch PC, credit-limited imem requests, in-order prefetch queue, redirect/halt.
// Optional perf counters (perf_fetched/perf_dropped/perf_stall) are built when FETCH_PERF_CNT_EN is defined.
module fetch_prefetch_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc_plus_4,
  output logic [XLEN-1:0] inst_data,
  output logic            misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped,
  output logic [31:0]     perf_stall
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  q_pc   [DEPTH];
  logic [XLEN-1:0]  q_data [DEPTH];
  logic [XLEN-1:0]  a_pc   [DEPTH];
  logic [PTR_W-1:0] q_head, q_tail, a_head, a_tail;
  logic [CNT_W-1:0] count, inflight, drop_cnt;
  logic [CNT_W-1:0] count_nxt, inflight_nxt, drop_nxt;
  logic             credit_ok, issue, rsp_drop, push, pop;

  // Queued plus outstanding entries never exceed DEPTH, so a push always has a free slot.
  assign credit_ok      = (SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(DEPTH);
  assign imem_req_valid = !reset && !halt && !misalign_err && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign issue          = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (redirect_valid || (drop_cnt != '0));
  assign push           = imem_rsp_valid && !rsp_drop;
  assign pop            = inst_valid && inst_ready && !redirect_valid;

  assign inst_valid     = (count != '0);
  assign inst_pc        = q_pc[q_head];
  assign inst_data      = q_data[q_head];
  assign inst_pc_plus_4 = inst_pc + XLEN'(4);

  always_comb begin
    count_nxt    = count;
    drop_nxt     = drop_cnt;
    inflight_nxt = inflight + CNT_W'(issue) - CNT_W'(imem_rsp_valid);
    if (redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old path.
      count_nxt = '0;
      drop_nxt  = inflight_nxt;
    end else begin
      if (push && !pop) begin
        count_nxt = count + CNT_W'(1);
      end else if (pop && !push) begin
        count_nxt = count - CNT_W'(1);
      end
      if (rsp_drop) begin
        drop_nxt = drop_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc     <= RESET_PC;
      count        <= '0;
      inflight     <= '0;
      drop_cnt     <= '0;
      misalign_err <= 1'b0;
      q_head       <= '0;
      q_tail       <= '0;
      a_head       <= '0;
      a_tail       <= '0;
    end else begin
      count    <= count_nxt;
      inflight <= inflight_nxt;
      drop_cnt <= drop_nxt;
      if (redirect_valid) begin
        fetch_pc     <= redirect_pc;
        misalign_err <= |redirect_pc[1:0];
        q_head       <= '0;
        q_tail       <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + XLEN'(4);
        if (push)  q_tail   <= q_tail + PTR_W'(1);
        if (pop)   q_head   <= q_head + PTR_W'(1);
      end
      // Issued-address FIFO tracks every request, dropped or not, to stay aligned with responses.
      if (issue)          a_tail <= a_tail + PTR_W'(1);
      if (imem_rsp_valid) a_head <= a_head + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (issue) a_pc[a_tail] <= fetch_pc;
    if (push) begin
      q_pc[q_tail]   <= a_pc[a_head];
      q_data[q_tail] <= imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
      perf_stall   <= '0;
    end else begin
      if (push && (perf_fetched != '1))     perf_fetched <= perf_fetched + 32'd1;
      if (rsp_drop && (perf_dropped != '1)) perf_dropped <= perf_dropped + 32'd1;
      if (inst_ready && !inst_valid && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: variable-latency memory model plus a request/delivery scoreboard.
// Perf counter checks are included when FETCH_PERF_CNT_EN is defined.
module tb_fetch_prefetch_unit;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset, halt, redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid, imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            inst_valid, inst_ready;
  logic [XLEN-1:0] inst_pc, inst_pc_plus_4, inst_data;
  logic            misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     perf_fetched, perf_dropped, perf_stall;
  logic [31:0]     m_fetched, m_dropped, m_stall;
`endif

  always #5 clk = ~clk;

  fetch_prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc),
    .inst_pc_plus_4(inst_pc_plus_4), .inst_data(inst_data), .misalign_err(misalign_err)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped), .perf_stall(perf_stall)
`endif
  );

  typedef struct { logic [31:0] addr; int due; } mem_t;
  typedef struct { logic [31:0] addr; bit dropped; } req_t;

  mem_t        mem_q[$];
  req_t        infl_q[$];
  logic [31:0] deliv_q[$];
  logic [31:0] exp_pc;
  bit          exp_mis;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  int          first_req_cyc = -1;
  int          first_inst_cyc = -1;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: present memory response, compare outputs, advance the reference model.
  task automatic cycle();
    bit   exp_rv, was_empty;
    req_t r;
    int   d;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memfn(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    exp_rv = !halt && !exp_mis && !redirect_valid && (infl_q.size() + deliv_q.size() < DEPTH);
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) check("req_addr", imem_req_addr, exp_pc);
    check("inst_valid", 32'(inst_valid), 32'(deliv_q.size() != 0));
    if (deliv_q.size() != 0 && inst_valid) begin
      check("inst_pc", inst_pc, deliv_q[0]);
      check("inst_data", inst_data, memfn(deliv_q[0]));
      check("inst_pc_plus_4", inst_pc_plus_4, deliv_q[0] + 32'd4);
    end
    check("misalign_err", 32'(misalign_err), 32'(exp_mis));
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_dropped", perf_dropped, m_dropped);
    check("perf_stall", perf_stall, m_stall);
`endif
    if (first_req_cyc < 0 && imem_req_valid && imem_req_ready) first_req_cyc = cyc;
    if (first_inst_cyc < 0 && inst_valid) first_inst_cyc = cyc;

    was_empty = (deliv_q.size() == 0);
    if (!redirect_valid && inst_ready && !was_empty) void'(deliv_q.pop_front());
    if (imem_rsp_valid) begin
      void'(mem_q.pop_front());
      if (infl_q.size() != 0) begin
        r = infl_q.pop_front();
`ifdef FETCH_PERF_CNT_EN
        if (redirect_valid || r.dropped) m_dropped++;
        else m_fetched++;
`endif
        if (!redirect_valid && !r.dropped) deliv_q.push_back(r.addr);
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mem_q.push_back('{addr: imem_req_addr, due: d});
      infl_q.push_back('{addr: exp_pc, dropped: 1'b0});
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid) begin
      deliv_q.delete();
      foreach (infl_q[i]) infl_q[i].dropped = 1'b1;
      exp_pc  = redirect_pc;
      exp_mis = |redirect_pc[1:0];
    end
`ifdef FETCH_PERF_CNT_EN
    if (inst_ready && was_empty) m_stall++;
`endif
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Asynchronous reset; the memory model is flushed with it.
  task automatic do_reset();
    reset          = 1'b1;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    mem_q.delete();
    infl_q.delete();
    deliv_q.delete();
    exp_pc         = 32'h0;
    exp_mis        = 1'b0;
    first_req_cyc  = -1;
    first_inst_cyc = -1;
`ifdef FETCH_PERF_CNT_EN
    m_fetched = '0; m_dropped = '0; m_stall = '0;
`endif
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_fetched", perf_fetched, 32'd0);
    check("rst_perf_stall", perf_stall, 32'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    cyc++;
    last_due = cyc;
    reset    = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_pc    = pc;
    redirect_valid = 1'b1;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b1;
    do_reset();

    // Streaming from RESET_PC with a 1-cycle memory.
    lat = 1;
    repeat (8) cycle();
    check("first_inst_latency", 32'(first_inst_cyc - first_req_cyc), 32'd2);

    // Decode stall fills the credit window.
    inst_ready = 1'b0;
    repeat (10) cycle();
    check("stall_req_blocked", 32'(imem_req_valid), 32'd0);
    check("stall_queue_full", 32'(inst_valid), 32'd1);
    inst_ready = 1'b1;
    repeat (8) cycle();

    // Redirect with several requests in flight on a 3-cycle memory.
    lat = 3;
    repeat (10) cycle();
    redirect_to(32'h100);
    for (int i = 0; i < 20 && !inst_valid; i++) cycle();
    check("redirect_valid_arrives", 32'(inst_valid), 32'd1);
    check("redirect_first_pc", inst_pc, 32'h100);
    repeat (4) cycle();

    // Redirect coinciding with a response and a pop.
    lat = 1;
    repeat (6) cycle();
    redirect_to(32'h40);
    check("flush_after_redirect", 32'(inst_valid), 32'd0);
    repeat (6) cycle();

    // Halt drains in-flight work, then resumes sequentially.
    lat = 3;
    repeat (6) cycle();
    halt = 1'b1;
    repeat (12) cycle();
    check("halt_no_req", 32'(imem_req_valid), 32'd0);
    check("halt_drained", 32'(inst_valid), 32'd0);
    halt = 1'b0;
    repeat (10) cycle();

    // Misaligned target stalls fetch until an aligned redirect.
    lat = 1;
    redirect_to(32'h102);
    repeat (6) cycle();
    check("misalign_set", 32'(misalign_err), 32'd1);
    redirect_to(32'h200);
    repeat (8) cycle();
    check("misalign_cleared", 32'(misalign_err), 32'd0);

    // PC wrap at the top of the address space.
    redirect_to(32'hFFFF_FFF8);
    repeat (8) cycle();

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      if (i % 250 == 0) lat = $urandom_range(1, 4);
      inst_ready     = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) halt = !halt;
      redirect_valid = ($urandom_range(0, 29) == 0);
      if (redirect_valid) redirect_pc = ($urandom_range(0, 7) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC);
      cycle();
    end
    redirect_valid = 1'b0;
    halt           = 1'b0;
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;

    // Reset in the middle of traffic.
    lat = 2;
    redirect_to(32'h300);
    repeat (5) cycle();
    do_reset();
    repeat (10) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
